// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit. Holds the data-path
//            width, the access-type codes, the FSM state type and a
//            helper that checks whether an access type is legal.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  // Access-type codes.
  // op[3]   = store
  // op[2]   = zero-extend (loads)
  // op[1:0] = size: 00 byte, 01 halfword, 10 word
  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational lane logic for the load/store unit. Picks the
//            addressed byte or halfword out of a memory word and extends it
//            for loads. For stores, it builds the full word to write back.
// Ports    : op_lo       - op[2:0] of the access in flight
//            byte_off    - addr[1:0] of the access in flight
//            rd_word     - word read from memory
//            store_data  - store operand (value in the low lanes)
//            load_value  - extended load result
//            merged_word - word to write back (merge for SB/SH, operand for SW)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]      op_lo,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] rd_word,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_value,
  output logic [XLEN-1:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    // Little-endian: byte k sits at bits [8k+7:8k].
    // The halfword is chosen by addr[1].
    sel_byte = rd_word[{byte_off, 3'b000} +: 8];
    sel_half = rd_word[{byte_off[1], 4'b0000} +: 16];

    case (op_lo[1:0])
      2'b00:   load_value = op_lo[2] ? {24'd0, sel_byte}
                                     : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_value = op_lo[2] ? {16'd0, sel_half}
                                     : {{16{sel_half[15]}}, sel_half};
      default: load_value = rd_word;
    endcase

    merged_word = rd_word;
    case (op_lo[1:0])
      2'b00:   merged_word[{byte_off, 3'b000} +: 8]     = store_data[7:0];
      2'b01:   merged_word[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Runs byte, halfword and word loads and stores against a
//            single-port word memory.
//            - SB/SH use a read-modify-write: READ, then WRITE.
//            - SW writes directly.
//            - A faulting request goes straight to RESP with err set.
// Ports    : clk, rst               - clock, async active-high reset
//            req, op, addr, storeData - request (sampled in IDLE/RESP only)
//            busy, done, err, loadData - status and load result
//            memAddress, memWriteData, memWrite, memRead, memReadData
//                                    - memory side (word-indexed)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] storeData,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] loadData,
  output logic [XLEN-1:0] memAddress,
  output logic [XLEN-1:0] memWriteData,
  output logic            memWrite,
  output logic            memRead,
  input  logic [XLEN-1:0] memReadData
);

  lsu_state_t      state;
  logic [3:0]      op_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] store_q;

  logic [XLEN-1:0] word_idx;
  logic            misaligned;
  logic            fault;
  logic            accept;
  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] merged_word;

  assign word_idx = {2'b00, addr[XLEN-1:2]};

  always_comb begin
    misaligned = 1'b0;
    if (op[1:0] == 2'b10)      misaligned = (addr[1:0] != 2'b00);
    else if (op[1:0] == 2'b01) misaligned = addr[0];
    fault = !op_is_legal(op) || misaligned || (word_idx >= 32'(DEPTH));
  end

  // RESP can take a new request on its closing edge, so back-to-back
  // requests lose no cycle.
  assign accept = req && ((state == ST_IDLE) || (state == ST_RESP));

  lsu_lane_align u_align (
    .op_lo       (op_q[2:0]),
    .byte_off    (off_q),
    .rd_word     (memReadData),
    .store_data  (store_q),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      off_q        <= '0;
      store_q      <= '0;
      err          <= 1'b0;
      loadData     <= '0;
      memAddress   <= '0;
      memWriteData <= '0;
    end else begin
      case (state)
        ST_READ: begin
          if (op_q[3]) begin
            memWriteData <= merged_word;
            state        <= ST_WRITE;
          end else begin
            loadData <= load_value;
            state    <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        default:  state <= ST_IDLE;
      endcase

      // accept is only true in IDLE/RESP, so it never collides with the
      // READ assignments above.
      if (accept) begin
        op_q       <= op;
        off_q      <= addr[1:0];
        store_q    <= storeData;
        memAddress <= word_idx;
        err        <= fault;
        if (fault) begin
          loadData <= '0;
          state    <= ST_RESP;
        end else if (op == OP_SW) begin
          memWriteData <= storeData;
          state        <= ST_WRITE;
        end else begin
          state <= ST_READ;
        end
      end
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_RESP);
  assign memRead = (state == ST_READ);
  // Gate with rst so a reset landing inside WRITE never commits the merge.
  assign memWrite = (state == ST_WRITE) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. It has a word-memory
//            model and a byte-level reference model of the access rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] loadData;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData = '0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_load;

  int nvec  = 0;
  int nfail = 0;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .op           (op),
    .addr         (addr),
    .storeData    (storeData),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .loadData     (loadData),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .memReadData  (memReadData)
  );

  always #5 clk = ~clk;

  // Memory: the read word appears on the falling edge inside READ.
  // The write commits on the rising edge.
  always @(negedge clk) if (memRead)  memReadData <= mem[memAddress[9:0]];
  always @(posedge clk) if (memWrite) mem[memAddress[9:0]] <= memWriteData;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, written in byte terms. It returns the expected err,
  // latency, read/write counts and write word. It also updates ref_mem
  // and ref_load.
  task automatic ref_step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd,
                          output logic e_err, output int e_lat, output int e_rd,
                          output int e_wr, output logic [31:0] e_wd);
    int unsigned nbytes;
    int unsigned idx;
    int unsigned sh;
    bit          is_store;
    bit          is_signed;
    logic [31:0] mask;
    logic [31:0] w;
    logic [31:0] v;
    case (o)
      4'b0000, 4'b0100, 4'b1000: nbytes = 1;
      4'b0001, 4'b0101, 4'b1001: nbytes = 2;
      4'b0010, 4'b1010:          nbytes = 4;
      default:                   nbytes = 0;
    endcase
    is_store  = (o == 4'b1000) || (o == 4'b1001) || (o == 4'b1010);
    is_signed = (o == 4'b0000) || (o == 4'b0001);
    idx  = a / 4;
    e_rd = 0;
    e_wr = 0;
    e_wd = '0;
    if (nbytes == 0 || (a % nbytes) != 0 || idx >= DEPTH) begin
      e_err    = 1'b1;
      e_lat    = 1;
      ref_load = '0;
    end else begin
      e_err = 1'b0;
      sh    = (a % 4) * 8;
      mask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      w     = ref_mem[idx];
      if (!is_store) begin
        v = (w >> sh) & mask;
        if (is_signed && v[8*nbytes-1]) v = v | ~mask;
        ref_load = v;
        e_rd     = 1;
        e_lat    = 2;
      end else begin
        if (nbytes == 4) begin
          e_wd  = sd;
          e_lat = 2;
        end else begin
          e_wd  = (w & ~(mask << sh)) | ((sd & mask) << sh);
          e_rd  = 1;
          e_lat = 3;
        end
        e_wr         = 1;
        ref_mem[idx] = e_wd;
      end
    end
  endtask

  // One request, with the bus watched until done (bounded). Every
  // observation is checked against the model.
  task automatic do_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd,
                        input string tag, output logic [31:0] got_ld,
                        output logic [31:0] got_wd, output int got_lat);
    logic        e_err;
    int          e_lat;
    int          e_rd;
    int          e_wr;
    logic [31:0] e_wd;
    int          n_rd    = 0;
    int          n_wr    = 0;
    bit          seen    = 0;
    logic        got_err = 1'bx;
    logic [31:0] got_ma  = 'x;
    got_ld  = 'x;
    got_wd  = 'x;
    got_lat = 0;
    ref_step(o, a, sd, e_err, e_lat, e_rd, e_wr, e_wd);
    @(negedge clk);
    op        = o;
    addr      = a;
    storeData = sd;
    req       = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (memRead) n_rd++;
      if (memWrite) begin
        n_wr++;
        got_wd = memWriteData;
      end
      if (done) begin
        seen    = 1;
        got_lat = c;
        got_err = err;
        got_ld  = loadData;
        got_ma  = memAddress;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"},   32'(got_lat), 32'(e_lat));
    chk({tag, "_err"},       32'(got_err), 32'(e_err));
    chk({tag, "_loadData"},  got_ld, ref_load);
    chk({tag, "_reads"},     32'(n_rd), 32'(e_rd));
    chk({tag, "_writes"},    32'(n_wr), 32'(e_wr));
    chk({tag, "_memAddress"}, got_ma, a >> 2);
    if (e_wr != 0) chk({tag, "_wdata"}, got_wd, e_wd);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},     32'(busy), 32'd0);
    chk({tag, "_done"},     32'(done), 32'd0);
    chk({tag, "_err"},      32'(err), 32'd0);
    chk({tag, "_memRead"},  32'(memRead), 32'd0);
    chk({tag, "_memWrite"}, 32'(memWrite), 32'd0);
    chk({tag, "_loadData"}, loadData, 32'd0);
    chk({tag, "_memAddr"},  memAddress, 32'd0);
    chk({tag, "_memWdata"}, memWriteData, 32'd0);
  endtask

  logic [3:0] legal_ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                4'b0101, 4'b1000, 4'b1001, 4'b1010};

  initial begin
    logic [31:0] ld;
    logic [31:0] wd;
    int          lat;
    logic        e_err;
    int          e_lat;
    int          e_rd;
    int          e_wr;
    logic [31:0] e_wd;
    logic [7:0]  done_pat;
    logic [7:0]  busy_pat;
    logic [31:0] sd;
    int          done_cnt;

    rst       = 1'b1;
    req       = 1'b0;
    op        = '0;
    addr      = '0;
    storeData = '0;
    ref_load  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // SW then LW of the same word.
    do_req(OP_SW, 32'h10, 32'hDEADBEEF, "sw10", ld, wd, lat);
    chk("sw10_wd_const", wd, 32'hDEADBEEF);
    chk("sw10_addr_const", memAddress, 32'd4);
    do_req(OP_LW, 32'h10, 32'h0, "lw10", ld, wd, lat);
    chk("lw10_ld_const", ld, 32'hDEADBEEF);

    // Byte merge followed by signed and unsigned loads.
    do_req(OP_SB, 32'h11, 32'h000000AA, "sb11", ld, wd, lat);
    chk("sb11_wd_const", wd, 32'hDEADAAEF);
    chk("sb11_lat_const", 32'(lat), 32'd3);
    do_req(OP_LB,  32'h11, 32'h0, "lb11",  ld, wd, lat);
    chk("lb11_const", ld, 32'hFFFFFFAA);
    do_req(OP_LBU, 32'h11, 32'h0, "lbu11", ld, wd, lat);
    chk("lbu11_const", ld, 32'h000000AA);
    do_req(OP_LH,  32'h12, 32'h0, "lh12",  ld, wd, lat);
    chk("lh12_const", ld, 32'hFFFFDEAD);
    do_req(OP_LHU, 32'h12, 32'h0, "lhu12", ld, wd, lat);
    chk("lhu12_const", ld, 32'h0000DEAD);

    // Faulting requests.
    do_req(OP_LW,   32'h13,       32'h0, "f_lw13", ld, wd, lat);
    chk("f_lw13_ld0", ld, 32'd0);
    do_req(OP_SH,   32'h11,       32'h5, "f_sh11", ld, wd, lat);
    do_req(4'b0111, 32'h0,        32'h0, "f_ill",  ld, wd, lat);
    do_req(OP_LW,   32'h00001000, 32'h0, "f_rng",  ld, wd, lat);
    chk("f_rng_lat_const", 32'(lat), 32'd1);

    // req held high through an SB. The LW behind it must wait for RESP exit.
    sd = $urandom;
    ref_step(OP_SB, 32'h20, sd, e_err, e_lat, e_rd, e_wr, e_wd);
    ref_step(OP_LW, 32'h20, 32'h0, e_err, e_lat, e_rd, e_wr, wd);
    done_pat = '0;
    busy_pat = '0;
    ld       = 'x;
    wd       = 'x;
    @(negedge clk);
    op        = OP_SB;
    addr      = 32'h20;
    storeData = sd;
    req       = 1'b1;
    @(posedge clk);
    #1;
    op   = OP_LW;
    addr = 32'h20;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      done_pat[c] = done;
      busy_pat[c] = busy;
      if (memWrite) wd = memWriteData;
      if (c == 5) ld = loadData;
      if (c == 4) req = 1'b0;
    end
    chk("hold_done_pattern", 32'(done_pat), 32'h28);
    chk("hold_busy_pattern", 32'(busy_pat), 32'h3E);
    chk("hold_sb_wdata", wd, e_wd);
    chk("hold_lw_data", ld, ref_load);

    // Reset in the middle of WRITE. The merge must not commit and done must
    // not pulse.
    @(negedge clk);
    op        = OP_SB;
    addr      = 32'h24;
    storeData = $urandom;
    req       = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_memWrite_before", 32'(memWrite), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_memWrite_after", 32'(memWrite), 32'd0);
    chk("rstw_busy_after", 32'(busy), 32'd0);
    ref_load = '0;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (c == 0) rst = 1'b0;
    end
    chk("rstw_no_done", 32'(done_cnt), 32'd0);
    chk_reset_state("rstw");

    // Random traffic against the reference model.
    for (int k = 0; k < 80; k++) begin
      logic [3:0]  o;
      logic [31:0] a;
      if ($urandom_range(0, 9) < 8) o = legal_ops[$urandom_range(0, 7)];
      else                          o = 4'($urandom);
      if ($urandom_range(0, 19) == 0) a = $urandom;
      else                            a = 32'($urandom_range(0, 4 * DEPTH + 15));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_req(o, a, $urandom, "rnd", ld, wd, lat);
    end

    // Memory image must match the model, including the aborted SB.
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) chk("mem_image", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
